// File: rtl/uart_mmio_tx.sv
// Memory-mapped UART transmitter: CPU stores feed a byte FIFO that an 8N1 serialiser drains.
// A status register reports FIFO occupancy, sticky overflow and transmitter activity.
module uart_mmio_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [15:0] TX_ADDR      = 16'hFFF0,
    parameter logic [15:0] STATUS_ADDR  = 16'hFFF1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_write_en,
    input  logic [15:0] mem_write_addr,
    input  logic [15:0] mem_write_data,
    input  logic        mem_read_en,
    input  logic [15:0] mem_read1_addr,
    output logic [15:0] status_data,
    output logic        status_hit,
    output logic        tx,
    output logic        busy,
    output logic        overflow
);

    localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0]  DEPTH_C   = 5'(FIFO_DEPTH);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [7:0]    head_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [4:0]    count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   status_data_q;
    logic          status_hit_q;

    logic          push_req, push_ok, pop, clr_req, stat_rd;
    logic          fifo_empty, fifo_full, bit_done, busy_w;
    logic [15:0]   status_word;

    // The upper store byte has no meaning for this peripheral.
    logic unused_hi;
    assign unused_hi = ^mem_write_data[15:8];

    assign push_req   = mem_write_en && (mem_write_addr == TX_ADDR);
    assign clr_req    = mem_write_en && (mem_write_addr == STATUS_ADDR) && mem_write_data[2];
    assign stat_rd    = mem_read_en && (mem_read1_addr == STATUS_ADDR);
    assign fifo_empty = (count_q == 5'd0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign pop        = (state_q == IDLE) && !fifo_empty;
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign bit_done   = (baud_q == BAUD_LAST);
    assign busy_w     = (state_q != IDLE);

    always_comb begin
        status_word       = 16'h0000;
        status_word[0]    = fifo_empty;
        status_word[1]    = fifo_full;
        status_word[2]    = overflow_q;
        status_word[3]    = busy_w;
        status_word[12:8] = count_q;
    end

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end else if (clr_req) begin
            overflow_d = 1'b0;
        end
    end

    // Storage and its registered read; the head byte is captured on the pop edge.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= mem_write_data[7:0];
        end
        if (pop) begin
            head_q <= fifo_mem[rd_ptr_q];
        end
    end

    // tx_d is derived from the next state so the line changes exactly at boundaries.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                baud_d = 16'd0;
                tx_d   = 1'b1;
                if (pop) begin
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    shift_d = head_q;
                    tx_d    = head_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                    baud_d  = 16'd0;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = 16'd0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            baud_q        <= 16'd0;
            bit_q         <= 3'd0;
            shift_q       <= 8'h00;
            tx_q          <= 1'b1;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= 5'd0;
            overflow_q    <= 1'b0;
            status_data_q <= 16'h0000;
            status_hit_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            status_hit_q <= stat_rd;
            if (stat_rd) begin
                status_data_q <= status_word;
            end
        end
    end

    assign status_data = status_data_q;
    assign status_hit  = status_hit_q;
    assign tx          = tx_q;
    assign busy        = busy_w;
    assign overflow    = overflow_q;

endmodule

// File: doc/uart_mmio_tx.md
UART_MMIO_TX -- requirements
Module: uart_mmio_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868: clock cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: transmit FIFO entries; legal values are powers of two, 2..16.
REQ-003 SHALL have parameter TX_ADDR, default 16'hFFF0: word address of the transmit-data register.
REQ-004 SHALL have parameter STATUS_ADDR, default 16'hFFF1: word address of the status register.
REQ-005 Ports SHALL be:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- mem_write_en  in  1  CPU store strobe.
- mem_write_addr  in  16  CPU store address.
- mem_write_data  in  16  CPU store data.
- mem_read_en  in  1  CPU load strobe.
- mem_read1_addr  in  16  CPU data-port load address.
- status_data  out  16  registered status word.
- status_hit  out  1  registered; status_data is valid for the preceding load.
- tx  out  1  registered serial line; idles high.
- busy  out  1  high when the FSM is not IDLE.
- overflow  out  1  sticky flag: a store was dropped.

Function
REQ-006 Push: a cycle with mem_write_en=1 and mem_write_addr==TX_ADDR SHALL enqueue mem_write_data[7:0]; bits [15:8] are ignored.
REQ-007 Push acceptance: a push SHALL be accepted when occupancy<FIFO_DEPTH, or when a pop occurs in the same cycle.
- Otherwise the byte SHALL be dropped and overflow set to 1 on the next edge.
REQ-008 Occupancy SHALL update as follows:
- +1 on push only.
- -1 on pop only.
- unchanged on simultaneous push and pop.
- Range 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
REQ-009 Overflow clear: a store to STATUS_ADDR with mem_write_data[2]=1 SHALL clear overflow.
- If a dropped push occurs in the same cycle, set SHALL win.
REQ-010 Status word layout:
- bit0 = empty.
- bit1 = full.
- bit2 = overflow.
- bit3 = busy.
- bits[12:8] = occupancy.
- all other bits 0.
REQ-011 Status read: on mem_read_en=1 with mem_read1_addr==STATUS_ADDR, status_data SHALL present the pre-edge status word and status_hit SHALL be 1 on the next edge (1-cycle latency, matching memory read latency).
- Otherwise status_hit SHALL be 0 and status_data SHALL hold its value.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE with occupancy>0 SHALL pop the head byte into the shift register and enter START on the next edge.
- An IDLE cycle with an empty FIFO SHALL remain IDLE.
REQ-014 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then enter DATA.
REQ-015 DATA SHALL shift out 8 bits, LSB first, each held CLKS_PER_BIT cycles, then enter STOP.
- A 3-bit counter tracks the bit index.
- A baud counter runs 0..CLKS_PER_BIT-1 and is reset on every state entry.
REQ-016 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
- Consecutive frame start edges SHALL be exactly 10*CLKS_PER_BIT+1 cycles apart.
REQ-017 tx SHALL be registered and change only at state or bit boundaries.
- busy SHALL be high in START, DATA and STOP.
REQ-018 A push to an empty FIFO while IDLE SHALL be popped on the following cycle.
- tx SHALL fall 2 edges after the store cycle.
REQ-019 Stores to other addresses and loads of other addresses SHALL have no effect on FIFO, FSM or overflow.

Reset
REQ-020 When rst_n=0 at an edge, the following SHALL hold after that edge:
- FSM = IDLE.
- tx = 1.
- busy = 0.
- FIFO empty, pointers = 0.
- overflow = 0.
- status_data = 0.
- status_hit = 0.
REQ-021 Reset SHALL take priority over pushes, pops and clears in the same cycle.
REQ-022 Reset mid-frame SHALL abort the frame (tx high on the next edge) and discard all queued bytes.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=16)
REQ-023 Single byte: store 16'h1255 to 16'hFFF0 ->
- tx low 4 cycles.
- then bits 1,0,1,0,1,0,1,0 at 4 cycles each.
- then high 4 cycles.
- busy high 40 cycles.
REQ-024 Overflow: 18 consecutive stores to 16'hFFF0 from idle ->
- bytes 1..17 transmitted in order.
- byte 18 dropped.
- overflow=1.
- status read returns bit2=1.
REQ-025 Status read: idle and empty, load 16'hFFF1 ->
- next cycle status_hit=1, status_data=16'h0001.
- load 16'h0000 -> status_hit=0.
REQ-026 Clear: store 16'h0004 to 16'hFFF1 after overflow -> overflow=0, status bit2=0.
REQ-027 Reset mid-frame: rst_n=0 during data bit 3 with 5 bytes queued ->
- next edge tx=1, busy=0.
- subsequent status read returns 16'h0001.
REQ-028 Decode: store to 16'hFFF2, and store to 16'hFFF0 with mem_write_en=0 -> no transmission, occupancy stays 0.
